// File: rtl/vga_pixel_feeder_if.sv
// Read-side port bundle of the framebuffer async FIFO as seen from the pixel feeder.
// The master (feeder) issues pops; the slave (FIFO) presents the show-ahead head and flags.
interface vga_pixel_feeder_if;
   logic [31:0] fifo_rdata;
   logic        fifo_rempty;
   logic        fifo_rfull;
   logic        fifo_rinc;

   modport master (
      input  fifo_rdata,
      input  fifo_rempty,
      input  fifo_rfull,
      output fifo_rinc
   );

   modport slave (
      output fifo_rdata,
      output fifo_rempty,
      output fifo_rfull,
      input  fifo_rinc
   );
endinterface

// File: rtl/vga_pixel_feeder.sv
// Pops RGB pixels from the framebuffer FIFO in lock-step with display-enable, resyncing on error.
// Optional grid output in non-streaming states when VGA_FEEDER_TESTPATTERN_EN is defined.
module vga_pixel_feeder #(
   parameter int unsigned HDISP       = 800,
   parameter int unsigned VDISP       = 480,
   parameter int unsigned DRAIN_QUIET = 4
) (
   input  logic                 pixel_clk,
   input  logic                 pixel_rst,
   input  logic                 de_i,
   input  logic                 sof_i,
   vga_pixel_feeder_if.master   fifo,
   output logic [23:0]          rgb_o,
   output logic                 resync_o,
   output logic                 underrun_o
);

   localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
   localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
   localparam int unsigned QW = $clog2(DRAIN_QUIET + 1);

   localparam logic [XW-1:0] XMax     = XW'(HDISP - 1);
   localparam logic [YW-1:0] YMax     = YW'(VDISP - 1);
   localparam logic [QW-1:0] QuietEnd = QW'(DRAIN_QUIET - 1);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StArmed  = 2'd1;
   localparam logic [1:0] StStream = 2'd2;
   localparam logic [1:0] StDrain  = 2'd3;

   logic [1:0]    r_state, w_state_nxt;
   logic [XW-1:0] r_x, w_x_nxt, w_xc;
   logic [YW-1:0] r_y, w_y_nxt, w_yc;
   logic [QW-1:0] r_quiet, w_quiet_nxt;
   logic [23:0]   r_rgb, w_rgb_nxt;
   logic          r_resync;
   logic          r_underrun;
   logic          w_active;
   logic          w_misalign;
   logic          w_err;
   logic          w_show;
   logic          w_count;
   logic          w_pop;
   logic          w_unused_rdata;

   assign w_unused_rdata = ^fifo.fifo_rdata[31:24];

   always_comb begin
      // The sof_i cycle out of ARMED is already a streaming pixel.
      w_active   = (r_state == StStream) || ((r_state == StArmed) && sof_i);
      w_xc       = ((r_state != StStream) && sof_i) ? '0 : r_x;
      w_yc       = ((r_state != StStream) && sof_i) ? '0 : r_y;
      w_misalign = (r_state == StStream) && sof_i && ((r_x != '0) || (r_y != '0));
      w_err      = w_misalign || (w_active && de_i && fifo.fifo_rempty);
      w_show     = w_active && de_i && !w_err;
      w_pop      = w_show || ((r_state == StDrain) && !fifo.fifo_rempty);
      w_rgb_nxt  = w_show ? fifo.fifo_rdata[23:0] : 24'h000000;
      w_count    = w_show;
`ifdef VGA_FEEDER_TESTPATTERN_EN
      if (!w_active && de_i) begin
         w_count   = 1'b1;
         w_rgb_nxt = ((w_xc[3:0] == 4'd0) || (w_yc[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
      end
`endif
   end

   always_comb begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
      if (w_err) begin
         w_x_nxt = '0;
         w_y_nxt = '0;
      end else if (w_count) begin
         if (w_xc == XMax) begin
            w_x_nxt = '0;
            w_y_nxt = (w_yc == YMax) ? '0 : w_yc + YW'(1);
         end else begin
            w_x_nxt = w_xc + XW'(1);
            w_y_nxt = w_yc;
         end
      end else if (r_state != StStream) begin
         w_x_nxt = w_xc;
         w_y_nxt = w_yc;
`ifndef VGA_FEEDER_TESTPATTERN_EN
         w_x_nxt = '0;
         w_y_nxt = '0;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_quiet_nxt = '0;
      case (r_state)
         StIdle: begin
            if (fifo.fifo_rfull) w_state_nxt = StArmed;
         end
         StArmed: begin
            if (w_err)      w_state_nxt = StDrain;
            else if (sof_i) w_state_nxt = StStream;
         end
         StStream: begin
            if (w_err) w_state_nxt = StDrain;
         end
         StDrain: begin
            // Only an unbroken run of empty cycles counts as drained.
            if (fifo.fifo_rempty) begin
               if (r_quiet == QuietEnd) w_state_nxt = StIdle;
               else                     w_quiet_nxt = r_quiet + QW'(1);
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge pixel_clk or negedge pixel_rst) begin
      if (!pixel_rst) begin
         r_state    <= StIdle;
         r_x        <= '0;
         r_y        <= '0;
         r_quiet    <= '0;
         r_rgb      <= '0;
         r_resync   <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_x        <= w_x_nxt;
         r_y        <= w_y_nxt;
         r_quiet    <= w_quiet_nxt;
         r_rgb      <= w_rgb_nxt;
         r_resync   <= (w_state_nxt == StDrain);
         r_underrun <= r_underrun | w_err;
      end
   end

   assign fifo.fifo_rinc = w_pop;
   assign rgb_o          = r_rgb;
   assign resync_o       = r_resync;
   assign underrun_o     = r_underrun;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Scoreboard bench for vga_pixel_feeder with a small FIFO/writer model and reduced frame size.
module tb_vga_pixel_feeder;
   localparam int unsigned HDISP       = 20;
   localparam int unsigned VDISP       = 6;
   localparam int unsigned DRAIN_QUIET = 4;
   localparam int unsigned DEPTH       = 8;

   typedef struct packed {
      logic [23:0] rgb;
      logic        res;
      logic        und;
   } exp_t;

   logic        pixel_clk = 1'b0;
   logic        pixel_rst = 1'b0;
   logic        de_i      = 1'b0;
   logic        sof_i     = 1'b0;
   logic [23:0] rgb_o;
   logic        resync_o;
   logic        underrun_o;

   vga_pixel_feeder_if ff ();

   vga_pixel_feeder #(
      .HDISP       (HDISP),
      .VDISP       (VDISP),
      .DRAIN_QUIET (DRAIN_QUIET)
   ) dut (
      .pixel_clk  (pixel_clk),
      .pixel_rst  (pixel_rst),
      .de_i       (de_i),
      .sof_i      (sof_i),
      .fifo       (ff),
      .rgb_o      (rgb_o),
      .resync_o   (resync_o),
      .underrun_o (underrun_o)
   );

   always #5 pixel_clk = ~pixel_clk;

   exp_t        exp_q[$];
   logic [31:0] fq[$];
   int unsigned wr_next;
   bit          wr_en;
   bit          und_exp;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_pop    = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   task automatic drive_fifo();
      ff.fifo_rdata  = (fq.size() != 0) ? fq[0] : 32'hEE00_0000;
      ff.fifo_rempty = (fq.size() == 0);
      ff.fifo_rfull  = (fq.size() >= DEPTH);
   endtask

   // One pixel-clock cycle: drive, check the pop strobe, queue the post-edge expectation.
   task automatic cyc(input logic de, input logic sof, input logic pop, input logic show,
                      input logic res);
      exp_t e;
      logic p;
      @(negedge pixel_clk);
      de_i  = de;
      sof_i = sof;
      drive_fifo();
      #1;
      chk("fifo_rinc", 32'(ff.fifo_rinc), 32'(pop));
      chk("rinc_while_empty", 32'(ff.fifo_rinc & ff.fifo_rempty), 32'd0);
      e.rgb = (show && fq.size() != 0) ? fq[0][23:0] : 24'h000000;
      e.res = res;
      e.und = und_exp;
      exp_q.push_back(e);
      p = ff.fifo_rinc;
      @(posedge pixel_clk);
      if (p && fq.size() != 0) begin
         void'(fq.pop_front());
         n_pop++;
      end
      if (resync_o) wr_next = 1;
      else if (wr_en && fq.size() < DEPTH) begin
         fq.push_back({8'hA5, wr_next[23:0]});
         wr_next++;
      end
   endtask

   task automatic fill();
      for (int k = 0; k < 40 && fq.size() < DEPTH; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("fifo_filled", 32'(fq.size() >= DEPTH), 32'd1);
   endtask

   task automatic drain();
      int er = 0;
      for (int k = 0; k < 60 && er < DRAIN_QUIET; k++) begin
         logic pp;
         pp = (fq.size() != 0);
         if (!pp) er++;
         cyc(k[0], 1'b0, pp, 1'b0, er < DRAIN_QUIET);
      end
      chk("drain_quiet_cycles", 32'(er), 32'(DRAIN_QUIET));
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: compare registered outputs shortly after each active edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge pixel_clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rgb_o", 32'(rgb_o), 32'(e.rgb));
            chk("resync_o", 32'(resync_o), 32'(e.res));
            chk("underrun_o", 32'(underrun_o), 32'(e.und));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  p;
      int  hit;
      bit  done;
      wr_en   = 0;
      und_exp = 0;
      fq      = {32'hA500_0001, 32'hA500_0002, 32'hA500_0003};
      wr_next = 4;
      drive_fifo();
      de_i = 1'b1;

      // Reset state, with a non-empty FIFO and de_i high.
      repeat (2) @(negedge pixel_clk);
      #1;
      chk("reset_rgb_o", 32'(rgb_o), 32'd0);
      chk("reset_resync_o", 32'(resync_o), 32'd0);
      chk("reset_underrun_o", 32'(underrun_o), 32'd0);
      chk("reset_fifo_rinc", 32'(ff.fifo_rinc), 32'd0);
      pixel_rst = 1'b1;
      de_i      = 1'b0;

      // FIFO not full: de_i toggling and sof_i pulses must not start streaming.
      for (int i = 0; i < 12; i++) cyc(i[0], (i % 5) == 1, 1'b0, 1'b0, 1'b0);

      // Fill, then ARMED: nothing may be popped before sof_i.
      wr_en = 1;
      fill();
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Full frame with horizontal blanking.
      n_pop = 0;
      for (int y = 0; y < VDISP; y++) begin
         for (int x = 0; x < HDISP; x++) cyc(1'b1, (x == 0 && y == 0), 1'b1, 1'b1, 1'b0);
         repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("frame_pop_count", 32'(n_pop), 32'(HDISP * VDISP));

      // Second frame: aligned sof_i at (0,0), then a stray sof_i at (5,0).
      for (int x = 0; x < 5; x++) cyc(1'b1, (x == 0), 1'b1, 1'b1, 1'b0);
      und_exp = 1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      drain();

      // Restart, then starve the FIFO: underrun lands at pixel (10,2).
      fill();
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      p    = 0;
      hit  = -1;
      done = 0;
      for (int y = 0; y < VDISP && !done; y++) begin
         for (int x = 0; x < HDISP && !done; x++) begin
            if (p == 2 * HDISP + 2) wr_en = 0;
            if (fq.size() == 0) begin
               hit  = p;
               done = 1;
               cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
               cyc(1'b1, (p == 0), 1'b1, 1'b1, 1'b0);
               p++;
            end
         end
         if (!done) repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("underrun_pixel_index", 32'(hit), 32'(2 * HDISP + 10));
      wr_en = 1;
      drain();

      // Restart and stream, then reset mid-line.
      fill();
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int x = 0; x < 10; x++) cyc(1'b1, (x == 0), 1'b1, 1'b1, 1'b0);
      @(negedge pixel_clk);
      drive_fifo();
      #3;
      pixel_rst = 1'b0;
      #1;
      und_exp = 0;
      chk("async_rst_rgb_o", 32'(rgb_o), 32'd0);
      chk("async_rst_fifo_rinc", 32'(ff.fifo_rinc), 32'd0);
      chk("async_rst_resync_o", 32'(resync_o), 32'd0);
      chk("async_rst_underrun_o", 32'(underrun_o), 32'd0);
      repeat (2) begin
         @(posedge pixel_clk);
         #1;
         chk("in_rst_fifo_rinc", 32'(ff.fifo_rinc), 32'd0);
         chk("in_rst_rgb_o", 32'(rgb_o), 32'd0);
      end
      @(posedge pixel_clk);
      #2;
      pixel_rst = 1'b1;
      // IDLE after reset: sof_i alone is ignored, FIFO full arms on this edge.
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int x = 0; x < 6; x++) cyc(1'b1, (x == 0), 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge pixel_clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
